// File: rtl/strb_ram_ctrl.sv
// Word RAM back-end with a valid/ready request channel, per-byte write strobes,
// a registered read pipeline and an in-order, backpressure-buffered response channel.
module strb_ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_we,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);
    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFFS   = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDXW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int FDEPTH = RD_LATENCY + 2;
    localparam int PW     = $clog2(FDEPTH);
    localparam int CW     = $clog2(FDEPTH + 1);

    typedef struct packed {
        logic                  we;
        logic                  err;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic                  accept;
    logic                  pop;
    logic                  push;
    logic                  in_range;
    logic [IDXW-1:0]       word_idx;
    rsp_t                  new_entry;

    rsp_t                  stage     [RD_LATENCY];
    logic                  stage_vld [RD_LATENCY];

    rsp_t                  fifo_mem  [FDEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         outstanding_next;
    logic                  ready_q;
    rsp_t                  head;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept    = req_valid && req_ready;
    assign word_idx  = req_addr[OFFS +: IDXW];
    // The range test uses the whole byte address so any high bit set counts as out of range.
    assign in_range  = 64'(req_addr) < (64'(RAM_DEPTH) * 64'(BYTES));
    assign push      = stage_vld[RD_LATENCY-1];
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign head      = fifo_mem[rd_ptr];
    assign rsp_we    = rsp_valid && head.we;
    assign rsp_err   = rsp_valid && head.err;
    assign rsp_rdata = rsp_valid ? head.data : '0;
    assign req_ready = ready_q;

    always_comb begin
        new_entry.we   = req_we;
        new_entry.err  = !in_range;
        new_entry.data = (!req_we && in_range) ? mem[word_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_strb[i]) begin
                    mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline never stalls: the outstanding limit guarantees FIFO room at its exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                stage_vld[i] <= 1'b0;
                stage[i]     <= '0;
            end
        end else begin
            stage_vld[0] <= accept;
            stage[0]     <= new_entry;
            for (int i = 1; i < RD_LATENCY; i++) begin
                stage_vld[i] <= stage_vld[i-1];
                stage[i]     <= stage[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= stage[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    assign outstanding_next = outstanding + CW'(accept) - CW'(pop);

    // req_ready is a flop so it has no combinational path from rsp_ready or req_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
            ready_q     <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            ready_q     <= (outstanding_next < CW'(FDEPTH));
        end
    end

endmodule

// File: tb/tb_strb_ram_ctrl.sv
// Scoreboard bench for strb_ram_ctrl: one instance with RD_LATENCY=1, one with RD_LATENCY=2,
// exercised in turn against a byte-level reference memory.
module tb_strb_ram_ctrl;
    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_strb  [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic        rsp_we    [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          checks;
    int          failures;
    int          cycle;
    int          last_accept;
    logic        rr_mode;
    logic        rr_fixed;
    exp_t        exp_q0 [$];
    exp_t        exp_q1 [$];
    logic [31:0] model_mem [2][256];

    strb_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(256), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_strb(req_strb[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_we(rsp_we[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    strb_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(256), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_strb(req_strb[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_we(rsp_we[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycle = 0;
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic failTimeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=timeout required=event (t=%0t)", name, $time);
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic clear_q(input int k);
        if (k == 0) exp_q0.delete();
        else        exp_q1.delete();
    endtask

    // Reference model: a plain word array updated byte-wise, expectation queued at acceptance.
    task automatic model_issue(input int k, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] idx;
        exp_t        e;
        idx   = addr >> 2;
        e.we  = we;
        e.err = (idx >= 32'd256);
        e.data = '0;
        if (we) begin
            if (!e.err) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) model_mem[k][idx[7:0]][8*b +: 8] = wdata[8*b +: 8];
                end
            end
        end else if (!e.err) begin
            e.data = model_mem[k][idx[7:0]];
        end
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                rsp_ready[k] = rr_mode ? 1'($urandom_range(0, 1)) : rr_fixed;
            end
        end
    end

    // Monitor: pops an expectation on every response handshake and checks held outputs.
    initial begin
        logic        hold_prev [2];
        logic [31:0] prev_data [2];
        logic        prev_err  [2];
        logic        prev_we   [2];
        exp_t        e;
        for (int k = 0; k < 2; k++) hold_prev[k] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (!rst_n) begin
                    hold_prev[k] = 1'b0;
                end else begin
                    if (hold_prev[k]) begin
                        checkOutput("hold_valid", 32'(rsp_valid[k]), 32'd1);
                        checkOutput("hold_rdata", rsp_rdata[k], prev_data[k]);
                        checkOutput("hold_err", 32'(rsp_err[k]), 32'(prev_err[k]));
                        checkOutput("hold_we", 32'(rsp_we[k]), 32'(prev_we[k]));
                    end
                    if (rsp_valid[k]) begin
                        if (q_size(k) == 0) begin
                            checkOutput("unexpected_rsp", 32'(rsp_valid[k]), 32'd0);
                        end else if (rsp_ready[k]) begin
                            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            checkOutput("rsp_we", 32'(rsp_we[k]), 32'(e.we));
                            checkOutput("rsp_err", 32'(rsp_err[k]), 32'(e.err));
                            checkOutput("rsp_rdata", rsp_rdata[k], e.data);
                        end
                    end
                    hold_prev[k] = rsp_valid[k] && !rsp_ready[k];
                    prev_data[k] = rsp_rdata[k];
                    prev_err[k]  = rsp_err[k];
                    prev_we[k]   = rsp_we[k];
                end
            end
        end
    end

    task automatic applyStimulus(input int k, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        logic accepted;
        accepted     = 1'b0;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_strb[k]  = strb;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                model_issue(k, we, addr, wdata, strb);
                last_accept = cycle + 1;
                accepted    = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid[k] = 1'b0;
        if (!accepted) failTimeout("req_accept");
    endtask

    task automatic wait_idle(input int k);
        for (int c = 0; c < 500 && q_size(k) != 0; c++) @(posedge clk);
        @(posedge clk);
        #1;
        if (q_size(k) != 0) failTimeout("drain");
    endtask

    task automatic stream_reads(input int k, input int n, input logic [31:0] base);
        int   sent;
        int   vcnt;
        int   bubbles;
        int   not_ready;
        logic seen;
        sent = 0; vcnt = 0; bubbles = 0; not_ready = 0; seen = 1'b0;
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b0;
        req_addr[k]  = base;
        req_strb[k]  = 4'h0;
        for (int c = 0; c < n + 50 && vcnt < n; c++) begin
            @(negedge clk);
            if (sent < n) begin
                if (req_ready[k]) begin
                    model_issue(k, 1'b0, req_addr[k], 32'h0, 4'h0);
                    sent++;
                end else begin
                    not_ready++;
                end
            end
            if (rsp_valid[k]) begin
                vcnt++;
                seen = 1'b1;
            end else if (seen) begin
                bubbles++;
            end
            @(posedge clk);
            #1;
            if (sent >= n) req_valid[k] = 1'b0;
            else           req_addr[k]  = base + 32'(sent * 4);
        end
        req_valid[k] = 1'b0;
        checkOutput("stream_rsp_count", 32'(vcnt), 32'(n));
        checkOutput("stream_bubbles", 32'(bubbles), 32'd0);
        checkOutput("stream_ready_low", 32'(not_ready), 32'd0);
    endtask

    task automatic backpressure(input int k);
        int   accepts;
        logic done;
        rr_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        accepts = 0;
        done    = 1'b0;
        req_valid[k] = 1'b1;
        req_we[k]    = 1'b0;
        req_addr[k]  = 32'h0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (req_ready[k]) begin
                model_issue(k, 1'b0, req_addr[k], 32'h0, 4'h0);
                accepts++;
                @(posedge clk);
                #1;
                req_addr[k] = 32'(accepts * 4);
            end else begin
                done = 1'b1;
            end
        end
        req_valid[k] = 1'b0;
        checkOutput("bp_accepts", 32'(accepts), 32'(k + 3));
        repeat (4) begin
            @(negedge clk);
            checkOutput("bp_ready_low", 32'(req_ready[k]), 32'd0);
        end
        rr_fixed = 1'b1;
        wait_idle(k);
    endtask

    task automatic reset_in_flight(input int k);
        rr_fixed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(k, 1'b0, 32'(i * 4), 32'h0, 4'h0);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_rsp_valid", 32'(rsp_valid[k]), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata[k], 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err[k]), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready[k]), 32'd0);
        clear_q(k);
        rr_fixed = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_ready_before_edge", 32'(req_ready[k]), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_ready_after_edge", 32'(req_ready[k]), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(k, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_idle(k);
    endtask

    initial begin
        logic got;
        checks    = 0;
        failures  = 0;
        rr_mode   = 1'b0;
        rr_fixed  = 1'b1;
        last_accept = 0;
        rst_n     = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = '0;
            req_wdata[k] = '0;
            req_strb[k]  = '0;
            rsp_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            checkOutput("reset_rsp_we", 32'(rsp_we[k]), 32'd0);
            checkOutput("reset_rsp_rdata", rsp_rdata[k], 32'd0);
            checkOutput("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 2; k++) begin
            $display("[TB] instance with RD_LATENCY=%0d", k + 1);
            for (int i = 0; i < 256; i++) applyStimulus(k, 1'b1, 32'(i * 4), $urandom, 4'hF);
            wait_idle(k);

            applyStimulus(k, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
            wait_idle(k);
            applyStimulus(k, 1'b0, 32'h10, 32'h0, 4'hF);
            got = 1'b0;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (rsp_valid[k]) begin
                    got = 1'b1;
                    checkOutput("read_latency", 32'(cycle - last_accept), 32'(k + 1));
                end
            end
            if (!got) failTimeout("read_latency");
            wait_idle(k);

            applyStimulus(k, 1'b1, 32'h20, 32'h11223344, 4'hF);
            applyStimulus(k, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
            applyStimulus(k, 1'b0, 32'h20, 32'h0, 4'h0);
            applyStimulus(k, 1'b1, 32'h24, 32'h55555555, 4'h0);
            applyStimulus(k, 1'b0, 32'h27, 32'h0, 4'hF);
            applyStimulus(k, 1'b0, 32'h400, 32'h0, 4'h0);
            applyStimulus(k, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF);
            applyStimulus(k, 1'b0, 32'h0, 32'h0, 4'h0);
            applyStimulus(k, 1'b0, 32'hFFFFFFFC, 32'h0, 4'h0);
            wait_idle(k);

            backpressure(k);
            stream_reads(k, 16, 32'h40);
            wait_idle(k);

            rr_mode = 1'b1;
            for (int i = 0; i < 150; i++) begin
                applyStimulus(k, 1'($urandom_range(0, 1)),
                              32'($urandom_range(0, 280) * 4 + $urandom_range(0, 3)),
                              $urandom, 4'($urandom_range(0, 15)));
            end
            rr_mode  = 1'b0;
            rr_fixed = 1'b1;
            wait_idle(k);

            reset_in_flight(k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/strb_ram_ctrl.md
Name: strb_ram_ctrl

Overview:
- Parametrised, handshaked successor to the team's simple word RAM.
- Adds a valid/ready request channel with byte-addressed accesses and per-byte write strobes.
- Adds a configurable registered read latency, an in-order valid/ready response channel with backpressure buffering, and error responses for out-of-range addresses.
- Sits behind the AXI slave front-end as its memory back-end.

Parameters:
- DATA_WIDTH, 32, data word width in bits; must be a multiple of 8 and at least 8.
- ADDR_WIDTH, 32, byte-address width.
- RAM_DEPTH, 256, number of DATA_WIDTH words.
- RD_LATENCY, 1, memory read pipeline depth; legal values are 1 or 2.

Ports:
- clk  input  1  Single clock; all logic samples on the rising edge.
- rst_n  input  1  Asynchronous, active-low reset.
- req_valid  input  1  Request present.
- req_ready  output  1  Block can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  Byte address.
- req_wdata  input  DATA_WIDTH  Write data.
- req_strb  input  DATA_WIDTH/8  Byte-lane write enables.
- rsp_valid  output  1  Response present.
- rsp_ready  input  1  Consumer accepts the response.
- rsp_we  output  1  Echo of req_we for this response.
- rsp_rdata  output  DATA_WIDTH  Read data; 0 for writes and errors.
- rsp_err  output  1  Address out of range.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: rsp_valid=0, rsp_we=0, rsp_rdata=0, rsp_err=0. The outstanding counter, pipeline and response FIFO are cleared, and in-flight requests are dropped with no response. Memory contents are not cleared. req_ready is 1 one cycle after rst_n deasserts.
- Reset mid-operation: responses are discarded and rsp_valid drops immediately on reset assertion.
- Handshakes: a request is accepted on a rising edge where req_valid && req_ready. A response completes on a rising edge where rsp_valid && rsp_ready.
- Address decode:
  - Word index = req_addr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored (aligned access).
  - Out of range: index >= RAM_DEPTH. The access has no memory effect and rsp_err=1.
- Write: committed at the acceptance edge. Lane i (bits 8i+7:8i) is updated only if req_strb[i]=1. strb=0 is a legal no-op write and still returns a response.
- Read: memory is sampled at the acceptance edge, so it sees all writes accepted on earlier edges.
  - Read-after-write on consecutive cycles returns the new data.
  - Same-edge read and write cannot occur: one request per cycle.
- Latency: for a request accepted at edge N with an empty response path, rsp_valid rises after edge N+RD_LATENCY.
- Ordering: responses are returned strictly in acceptance order, one per request, writes included.
- Backpressure:
  - Response FIFO depth is RD_LATENCY+2. outstanding = accepted minus completed responses, range 0..RD_LATENCY+2.
  - req_ready = (outstanding < RD_LATENCY+2). It is registered-path only, with no combinational dependence on rsp_ready or req_valid.
  - The counter increments on accept and decrements on completion; simultaneous accept and completion leaves it unchanged.
- Output stability: while rsp_valid && !rsp_ready, rsp_we, rsp_rdata and rsp_err are held stable.
- Throughput: with rsp_ready held high, 1 request and 1 response per cycle sustained, with no bubbles.
- Invalid strobes: req_strb is ignored for reads.

Test Plan:
- Reset, then write addr 0x10, data 0xDEADBEEF, strb 0xF; read 0x10 -> write response has rsp_err=0, rsp_rdata=0. Read response appears RD_LATENCY cycles after acceptance with 0xDEADBEEF.
- Write 0x20 with 0x11223344, then write 0x20 with 0xAABBCCDD, strb 0x5; read 0x20 -> 0x11BB33DD.
- Read addr 0x400 with RAM_DEPTH=256 and 32-bit data (index 256) -> rsp_err=1, rsp_rdata=0. A subsequent read of 0x0 shows no memory corruption.
- Backpressure: rsp_ready=0 while issuing reads of 0x0, 0x4, 0x8, ... -> req_ready drops after exactly RD_LATENCY+2 accepts. Head response stays stable. Releasing rsp_ready drains the responses in order.
- Streaming: 16 back-to-back reads with rsp_ready=1, RD_LATENCY=1 and 2 -> req_ready stays 1 and 16 consecutive rsp_valid cycles return the correct data.
- Assert rst_n=0 with 3 requests in flight -> rsp_valid=0 immediately. After release, no stale responses appear and previously written data is still readable.
